// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and derived totals shared by the
// sync generator and its counters.
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam bit HS_POL_DEF = 1'b0;
  localparam bit VS_POL_DEF = 1'b0;
  localparam int CW_DEF     = 10;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N counter with enable and programmable reset value. wrap flags the
// terminal count, so en && wrap is the carry into the next counter.
module wrap_counter #(
  parameter int             W       = 10,
  parameter int             N       = 800,
  parameter logic [W-1:0]   RST_VAL = W'(N - 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count_d,
  output logic [W-1:0] count_q,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_comb begin
    wrap    = (count_q == LAST);
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: advances (x,y) on each pixel strobe and registers
// syncs, blanking and line/frame pulses decoded from the new position.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit HS_POL    = HS_POL_DEF,
  parameter bit VS_POL    = VS_POL_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int VS_START = V_VISIBLE + V_FP;

  logic [CW-1:0] x_d, y_d;
  logic          h_wrap, v_wrap, v_en;
  logic          hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d;
  logic          hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

  function automatic logic in_win(input logic [CW-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

  // Vertical counter steps only on the horizontal carry of an enabled edge.
  assign v_en = pix_en & h_wrap;

  wrap_counter #(.W(CW), .N(H_TOTAL)) u_h_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pix_en),
    .count_d (x_d),
    .count_q (x),
    .wrap    (h_wrap)
  );

  wrap_counter #(.W(CW), .N(V_TOTAL)) u_v_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (v_en),
    .count_d (y_d),
    .count_q (y),
    .wrap    (v_wrap)
  );

  // Decode from the next position so every output lines up with x/y.
  always_comb begin
    hsync_d       = in_win(x_d, HS_START, HS_START + H_SYNC) ? HS_POL : ~HS_POL;
    vsync_d       = in_win(y_d, VS_START, VS_START + V_SYNC) ? VS_POL : ~VS_POL;
    video_on_d    = (int'(x_d) < H_VISIBLE) && (int'(y_d) < V_VISIBLE);
    line_start_d  = v_en;
    frame_start_d = v_en & v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen using a reduced 32x20 timing so whole
// frames fit in a short run; hsync active-low, vsync active-high.
module tb_vga_sync_gen;

  localparam int HV = 16, HF = 4, HSW = 6, HB = 6;
  localparam int VV = 12, VF = 2, VSW = 2, VB = 4;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b1;
  localparam int CW = 6;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          von;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          ls;
    logic          fs;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_en = 1'b0;
  logic          hsync, vsync, video_on, line_start, frame_start;
  logic [CW-1:0] x, y;

  obs_t sb[$];
  int   mx, my;
  int   n_cmp = 0;
  int   n_err = 0;
  obs_t last;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .CW(CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic obs_t model(input logic en);
    obs_t e;
    logic hw;
    hw = 1'b0;
    if (en) begin
      if (mx == HT - 1) begin
        mx = 0;
        hw = 1'b1;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    e.x   = CW'(mx);
    e.y   = CW'(my);
    e.hs  = (mx >= HV + HF && mx < HV + HF + HSW) ? HSP : ~HSP;
    e.vs  = (my >= VV + VF && my < VV + VF + VSW) ? VSP : ~VSP;
    e.von = (mx < HV) && (my < VV);
    e.ls  = hw;
    e.fs  = hw && (my == 0);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a = '{hs: hsync, vs: vsync, von: video_on, x: x, y: y, ls: line_start, fs: frame_start};
    return a;
  endfunction

  // One clock: drive pix_en, predict, then compare after the edge.
  task automatic step(input logic en);
    obs_t e;
    @(negedge clk);
    pix_en = en;
    sb.push_back(model(en));
    @(posedge clk);
    #1;
    e    = sb.pop_front();
    last = sample();
    n_cmp++;
    if (last !== e) begin
      n_err++;
      if (n_err < 30)
        $display("FAIL step @%0t: got hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b, expected hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b",
                 $time, last.hs, last.vs, last.von, last.x, last.y, last.ls, last.fs,
                 e.hs, e.vs, e.von, e.x, e.y, e.ls, e.fs);
    end
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n  = 1'b0;
    pix_en = 1'b0;
    mx = HT - 1;
    my = VT - 1;
    repeat (3) @(posedge clk);
    #1;
    e = '{hs: ~HSP, vs: ~VSP, von: 1'b0, x: CW'(HT - 1), y: CW'(VT - 1), ls: 1'b0, fs: 1'b0};
    n_cmp++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL reset_values: got %h expected %h", sample(), e);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_pulse();
    step(1'b1);
    n_cmp++;
    if (!(last.x === '0 && last.y === '0 && last.ls && last.fs && last.von &&
          last.hs === ~HSP && last.vs === ~VSP)) begin
      n_err++;
      $display("FAIL first_pulse: got x=%0d y=%0d ls=%b fs=%b von=%b, expected 0 0 1 1 1", last.x, last.y, last.ls, last.fs, last.von);
    end
    step(1'b0);
    n_cmp++;
    if (last.ls !== 1'b0 || last.fs !== 1'b0) begin
      n_err++;
      $display("FAIL pulse_width: got ls=%b fs=%b, expected 0 0", last.ls, last.fs);
    end
  endtask

  task automatic test_hline();
    int hs_cnt = 0, hs_first = -1, ls_cnt = 0, ls_x = -1, von_fall = -1;
    logic prev_von = 1'b1;
    for (int i = 0; i < HT; i++) begin
      step(1'b1);
      if (last.hs === HSP) begin
        if (hs_first < 0) hs_first = int'(last.x);
        hs_cnt++;
      end
      if (last.ls === 1'b1) begin ls_cnt++; ls_x = int'(last.x); end
      if (prev_von && !last.von && von_fall < 0) von_fall = int'(last.x);
      prev_von = last.von;
      step(1'b0);
      if (last.ls !== 1'b0) ls_cnt++;
    end
    n_cmp++;
    if (hs_cnt != HSW) begin n_err++; $display("FAIL hsync_width: got %0d expected %0d", hs_cnt, HSW); end
    n_cmp++;
    if (hs_first != HV + HF) begin n_err++; $display("FAIL hsync_start: got %0d expected %0d", hs_first, HV + HF); end
    n_cmp++;
    if (ls_cnt != 1 || ls_x != 0) begin n_err++; $display("FAIL line_start_count: got %0d at x=%0d expected 1 at x=0", ls_cnt, ls_x); end
    n_cmp++;
    if (von_fall != HV) begin n_err++; $display("FAIL video_on_fall: got %0d expected %0d", von_fall, HV); end
  endtask

  task automatic test_frame();
    int vs_cnt = 0, fs_cnt = 0, fs_a = -1, fs_b = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b1);
      if (i < FRAME && last.vs === VSP) vs_cnt++;
      if (last.fs === 1'b1) begin
        fs_cnt++;
        if (fs_a < 0) fs_a = i; else if (fs_b < 0) fs_b = i;
      end
      step(1'b0);
    end
    n_cmp++;
    if (vs_cnt != VSW * HT) begin n_err++; $display("FAIL vsync_width: got %0d expected %0d", vs_cnt, VSW * HT); end
    n_cmp++;
    if (fs_cnt != 2) begin n_err++; $display("FAIL frame_start_count: got %0d expected 2", fs_cnt); end
    n_cmp++;
    if (fs_b - fs_a != FRAME) begin n_err++; $display("FAIL frame_period: got %0d expected %0d", fs_b - fs_a, FRAME); end
  endtask

  task automatic test_hold();
    obs_t snap;
    int   guard = 0;
    while (!(mx == 10 && my == 8) && guard < 2 * FRAME) begin
      step(1'b1);
      guard++;
    end
    snap = last;
    for (int i = 0; i < 1000; i++) step(1'b0);
    n_cmp++;
    if (last.x !== 6'd10 || last.y !== 6'd8 || last.hs !== snap.hs || last.vs !== snap.vs ||
        last.von !== snap.von || last.ls || last.fs) begin
      n_err++;
      $display("FAIL hold_frozen: got x=%0d y=%0d ls=%b fs=%b expected x=10 y=8 pulses 0", last.x, last.y, last.ls, last.fs);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    int   guard = 0;
    while (!(mx == 23 && my == 15) && guard < 2 * FRAME) begin
      step(1'b1);
      guard++;
    end
    n_cmp++;
    if (last.hs !== HSP || last.vs !== VSP) begin
      n_err++;
      $display("FAIL pre_reset_sync: got hs=%b vs=%b expected %b %b", last.hs, last.vs, HSP, VSP);
    end
    @(negedge clk);
    pix_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    e = '{hs: ~HSP, vs: ~VSP, von: 1'b0, x: CW'(HT - 1), y: CW'(VT - 1), ls: 1'b0, fs: 1'b0};
    n_cmp++;
    if (sample() !== e) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", sample(), e);
    end
    mx = HT - 1;
    my = VT - 1;
    pix_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1);
    n_cmp++;
    if (last.x !== '0 || last.y !== '0 || last.fs !== 1'b1) begin
      n_err++;
      $display("FAIL restart_after_reset: got x=%0d y=%0d fs=%b expected 0 0 1", last.x, last.y, last.fs);
    end
  endtask

  task automatic test_tied();
    int fs_a = -1, fs_b = -1, vs_cnt = 0, wrap_x = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b1);
      if (i < FRAME && last.vs === VSP) vs_cnt++;
      if (last.ls === 1'b1) wrap_x++;
      if (last.fs === 1'b1) begin
        if (fs_a < 0) fs_a = i; else if (fs_b < 0) fs_b = i;
      end
    end
    n_cmp++;
    if (fs_b - fs_a != FRAME) begin n_err++; $display("FAIL tied_frame_period: got %0d expected %0d", fs_b - fs_a, FRAME); end
    n_cmp++;
    if (wrap_x != 2 * VT) begin n_err++; $display("FAIL tied_line_count: got %0d expected %0d", wrap_x, 2 * VT); end
    n_cmp++;
    if (vs_cnt != VSW * HT) begin n_err++; $display("FAIL tied_vsync_width: got %0d expected %0d", vs_cnt, VSW * HT); end
  endtask

  initial begin
    test_reset();
    test_first_pulse();
    test_hline();
    test_frame();
    test_hold();
    test_reset_mid();
    test_tied();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Consumes the single-cycle pixel-rate strobe produced by the design's pixel clock-enable generator and produces VGA horizontal/vertical sync, blanking, and pixel coordinates. It sits between the clock-enable generator and the pixel/framebuffer read logic. All logic runs in the system clock domain. The block advances one pixel position per clock in which the strobe is high.

## Interface
Parameters (defaults: 640x480@60):
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CW, 10, x/y counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel strobe; the pixel position advances one step on every clk edge where pix_en=1
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- video_on  out  1  current position is in the visible area
- x  out  CW  current horizontal position
- y  out  CW  current vertical position
- line_start  out  1  one-clk pulse when x becomes 0
- frame_start  out  1  one-clk pulse when (x,y) becomes (0,0)

## Operation
Totals:
- H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP (800 at defaults)
- V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP (525 at defaults)

Counting (on an edge with pix_en=1):
- x increments, wrapping H_TOTAL-1 → 0.
- y increments only when x wraps, wrapping V_TOTAL-1 → 0.
- No wrap is ever skipped. Counters never exceed their totals.

Decode, from the new (x,y) values:
- hsync is active iff H_VISIBLE+H_FP ≤ x < H_VISIBLE+H_FP+H_SYNC (656..751 at defaults).
- vsync is active iff V_VISIBLE+V_FP ≤ y < V_VISIBLE+V_FP+V_SYNC (490..491 at defaults).
- video_on = (x < H_VISIBLE) && (y < V_VISIBLE).
- line_start = 1 for the single clk following an edge where x wrapped to 0. Otherwise it is 0.
- frame_start = 1 for the single clk following an edge where both x and y wrapped to 0. Otherwise it is 0.

Hold behaviour:
- With pix_en=0, x, y, hsync, vsync and video_on hold their values.
- With pix_en=0, line_start and frame_start are 0.

Reset values (asynchronous, applied immediately on rst_n low):
- x = H_TOTAL-1, y = V_TOTAL-1
- hsync = ~HS_POL, vsync = ~VS_POL
- video_on = 0, line_start = 0, frame_start = 0

Consequence of the reset values: the first pix_en after reset release yields (0,0), with line_start=1 and frame_start=1.

## Timing
- All outputs are registered and update on the same clk edge as x/y. This gives one clk of latency from a sampled pix_en.
- All outputs are mutually consistent for the same (x,y) in every cycle. There is no cross-signal skew.
- pix_en may be high for consecutive cycles, including tied to 1. Each high cycle advances one position.
- pix_en is not required to be periodic.
- Reset mid-frame: outputs go to reset values asynchronously. Counting restarts as described above after rst_n deasserts. rst_n deassertion is synchronised externally.
- At the last position (799,524) with pix_en=1, the next state is (0,0) with both pulses high and vsync/hsync inactive.

## Structure
- Package vga_timing_pkg holds:
  - the default 640x480@60 timing constants
  - derived H_TOTAL/V_TOTAL
  - sync polarity constants
- Sub-module wrap_counter is instantiated twice (horizontal and vertical). It is a parameterized modulo-N counter with enable, reset value, and a wrap (carry) output. The horizontal carry ANDed with pix_en drives the vertical enable.

## Test plan
1. Reset, release, one pix_en pulse → x=0, y=0, video_on=1, line_start=1 and frame_start=1 for exactly one clk, hsync/vsync inactive.
2. pix_en every 2nd clk for 800 enables → hsync active for exactly 96 enables starting when x=656; video_on falls when x=640; line_start pulses once, at x=0.
3. Full frame (420000 enables) → vsync active for exactly 1600 enables (y=490..491); frame_start pulses exactly once; the next frame_start comes 420000 enables later.
4. pix_en held 0 for 1000 clks mid-line (x=300, y=200) → x, y, syncs and video_on frozen; pulses stay 0.
5. rst_n asserted at x=700, y=491 (hsync and vsync active) → all outputs go to reset values before the next clk edge; first enable after release gives (0,0) with frame_start.
6. pix_en tied 1 → same sequence as scenario 3, measured in clk cycles; no skipped wrap at x=799 or y=524.
